// File: rtl/ctrl_pkg.sv
// ctrl_pkg: types and constants shared by the stall controller and the Control unit.
//   stall_state_e : controller FSM states (RUN, MWAIT, HALT)
//   OP_*          : RV32I major opcodes decoded by Control
//   is_mem_op     : opcode touches data memory (load or store)
package ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      MWAIT = 2'd1,
      HALT  = 2'd2
   } stall_state_e;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   function automatic logic is_mem_op(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard detection between EX and ID.
//   rs1_i, rs2_i  : ID-stage source registers
//   rd_i          : EX-stage destination register
//   mem_read_i    : EX-stage instruction is a load
//   load_use_o    : ID needs the value the EX load has not produced yet
module hazard_detect
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  mem_read_i,
   output logic                  load_use_o
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign load_use_o = mem_read_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall/flush/freeze controller with data-memory wait FSM.
//   clk_i, rst_i                      : clock, asynchronous active-low reset
//   ID_Rs1_i, ID_Rs2_i, EX_Rd_i,
//   EX_MemRead_i                      : load-use hazard inputs
//   MEM_Access_i, dmem_ack_i          : data-memory handshake inputs
//   Branch_Taken_i                    : ID-stage branch resolved taken
//   dmem_req_o                        : data-memory request
//   PCWrite_o, IF_ID_Write_o          : front-end update enables
//   No_Op_o, Flush_o, Freeze_o        : bubble, IF/ID flush, global hold
//   Fault_o                           : sticky memory-timeout fault
//   stall_cnt_o, flush_cnt_o          : statistics, present only with STALL_STATS_EN
// Priority is freeze > load-use > flush; suppressed events reappear from held inputs.
module pipe_stall_ctrl
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int TIMEOUT_W   = 8,
   parameter int MEM_TIMEOUT = 200,
   parameter int CNT_W       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] ID_Rs1_i,
   input  logic [REG_ADDR_W-1:0] ID_Rs2_i,
   input  logic [REG_ADDR_W-1:0] EX_Rd_i,
   input  logic                  EX_MemRead_i,
   input  logic                  MEM_Access_i,
   input  logic                  Branch_Taken_i,
   input  logic                  dmem_ack_i,
   output logic                  dmem_req_o,
   output logic                  PCWrite_o,
   output logic                  IF_ID_Write_o,
   output logic                  No_Op_o,
   output logic                  Flush_o,
   output logic                  Freeze_o,
   output logic                  Fault_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   stall_state_e         state_q, state_d;
   logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                 fault_q, fault_d;
   logic                 freeze, dmem_req, load_use;

   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .rs1_i      (ID_Rs1_i),
      .rs2_i      (ID_Rs2_i),
      .rd_i       (EX_Rd_i),
      .mem_read_i (EX_MemRead_i),
      .load_use_o (load_use)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      fault_d    = fault_q;
      freeze     = 1'b0;
      dmem_req   = 1'b0;
      case (state_q)
         RUN: begin
            dmem_req = MEM_Access_i;
            // an access acked in its first cycle completes without stalling
            if (MEM_Access_i && !dmem_ack_i) begin
               freeze     = 1'b1;
               state_d    = MWAIT;
               wait_cnt_d = '0;
            end
         end
         MWAIT: begin
            dmem_req = 1'b1;
            if (dmem_ack_i) begin
               state_d = RUN;
            end else begin
               freeze     = 1'b1;
               wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
               if (wait_cnt_d == TIMEOUT_W'(MEM_TIMEOUT)) begin
                  state_d = HALT;
                  fault_d = 1'b1;
               end
            end
         end
         HALT: freeze = 1'b1;
         default: state_d = RUN;
      endcase
   end

   // reset abandons any outstanding request even though the FSM reads as RUN
   assign dmem_req_o    = rst_i && dmem_req;
   assign Freeze_o      = freeze;
   assign PCWrite_o     = !freeze && !load_use;
   assign IF_ID_Write_o = !freeze && !load_use;
   assign No_Op_o       = !freeze && load_use;
   assign Flush_o       = !freeze && !load_use && Branch_Taken_i;
   assign Fault_o       = fault_q;

`ifdef STALL_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = ((Freeze_o || No_Op_o) && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (Flush_o && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: vector table, directed multi-cycle sequences and a random run against a reference model.
module tb_pipe_stall_ctrl;

   localparam int AW   = 5;
   localparam int TW   = 8;
   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
`ifdef STALL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic [AW-1:0] ID_Rs1_i = '0, ID_Rs2_i = '0, EX_Rd_i = '0;
   logic          EX_MemRead_i = 1'b0, MEM_Access_i = 1'b0, Branch_Taken_i = 1'b0, dmem_ack_i = 1'b0;
   logic          dmem_req_o, PCWrite_o, IF_ID_Write_o, No_Op_o, Flush_o, Freeze_o, Fault_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: memory-wait progress tracked as plain counts
   bit m_wait, m_halt, m_fault;
   int m_waited, m_stall, m_flush;

   pipe_stall_ctrl #(
      .REG_ADDR_W(AW), .TIMEOUT_W(TW), .MEM_TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .EX_Rd_i(EX_Rd_i),
      .EX_MemRead_i(EX_MemRead_i), .MEM_Access_i(MEM_Access_i),
      .Branch_Taken_i(Branch_Taken_i), .dmem_ack_i(dmem_ack_i),
      .dmem_req_o(dmem_req_o), .PCWrite_o(PCWrite_o), .IF_ID_Write_o(IF_ID_Write_o),
      .No_Op_o(No_Op_o), .Flush_o(Flush_o), .Freeze_o(Freeze_o), .Fault_o(Fault_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit memrd, br;
      int rd, rs1, rs2;
      bit pc, nop, fl;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input bit acc, ack, br, memrd, input int rd, rs1, rs2);
      MEM_Access_i   = acc;
      dmem_ack_i     = ack;
      Branch_Taken_i = br;
      EX_MemRead_i   = memrd;
      EX_Rd_i        = AW'(rd);
      ID_Rs1_i       = AW'(rs1);
      ID_Rs2_i       = AW'(rs2);
      #2;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      #1;
      chk("rst.dmem_req", dmem_req_o, 0);
      chk("rst.fault", Fault_o, 0);
      tick();
      rst_i    = 1'b1;
      m_wait   = 0;
      m_halt   = 0;
      m_fault  = 0;
      m_waited = 0;
      m_stall  = 0;
      m_flush  = 0;
   endtask

   task automatic step(input bit acc, ack, br, memrd, input int rd, rs1, rs2);
      bit lu, frz, nop, fl;
      drive(acc, ack, br, memrd, rd, rs1, rs2);
      lu  = memrd && rd != 0 && (rd == rs1 || rd == rs2);
      frz = m_halt || (m_wait ? !ack : (acc && !ack));
      nop = !frz && lu;
      fl  = !frz && !lu && br;
      chk("rnd.freeze", Freeze_o, frz);
      chk("rnd.pcwrite", PCWrite_o, !frz && !lu);
      chk("rnd.ifid", IF_ID_Write_o, !frz && !lu);
      chk("rnd.noop", No_Op_o, nop);
      chk("rnd.flush", Flush_o, fl);
      chk("rnd.dmem_req", dmem_req_o, m_halt ? 0 : (m_wait ? 1 : acc));
      chk("rnd.fault", Fault_o, m_fault);
      chk("rnd.stall_cnt", stall_cnt_o, STATS ? m_stall : 0);
      chk("rnd.flush_cnt", flush_cnt_o, STATS ? m_flush : 0);
      tick();
      if ((frz || nop) && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
      if (m_halt) begin
      end else if (m_wait) begin
         if (ack) m_wait = 0;
         else begin
            m_waited++;
            if (m_waited == TMO) begin
               m_wait  = 0;
               m_halt  = 1;
               m_fault = 1;
            end
         end
      end else if (acc && !ack) begin
         m_wait   = 1;
         m_waited = 0;
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   halt_cycles;
      vecs[0] = '{memrd:1, br:0, rd:5,  rs1:0,  rs2:5,  pc:0, nop:1, fl:0};
      vecs[1] = '{memrd:1, br:0, rd:0,  rs1:0,  rs2:0,  pc:1, nop:0, fl:0};
      vecs[2] = '{memrd:0, br:0, rd:5,  rs1:5,  rs2:0,  pc:1, nop:0, fl:0};
      vecs[3] = '{memrd:1, br:1, rd:7,  rs1:7,  rs2:2,  pc:0, nop:1, fl:0};
      vecs[4] = '{memrd:1, br:1, rd:3,  rs1:4,  rs2:6,  pc:1, nop:0, fl:1};
      vecs[5] = '{memrd:0, br:0, rd:0,  rs1:0,  rs2:0,  pc:1, nop:0, fl:0};
      vecs[6] = '{memrd:1, br:0, rd:31, rs1:31, rs2:1,  pc:0, nop:1, fl:0};
      vecs[7] = '{memrd:1, br:1, rd:0,  rs1:5,  rs2:5,  pc:1, nop:0, fl:1};

      // reset state
      tick();
      chk("reset.pcwrite", PCWrite_o, 1);
      chk("reset.freeze", Freeze_o, 0);
      chk("reset.stall_cnt", stall_cnt_o, 0);
      chk("reset.flush_cnt", flush_cnt_o, 0);
      do_reset();

      foreach (vecs[i]) begin
         drive(0, 0, vecs[i].br, vecs[i].memrd, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
         chk($sformatf("vec%0d.pcwrite", i), PCWrite_o, vecs[i].pc);
         chk($sformatf("vec%0d.ifid", i), IF_ID_Write_o, vecs[i].pc);
         chk($sformatf("vec%0d.noop", i), No_Op_o, vecs[i].nop);
         chk($sformatf("vec%0d.flush", i), Flush_o, vecs[i].fl);
         chk($sformatf("vec%0d.freeze", i), Freeze_o, 0);
         tick();
      end

      // load-use lasts exactly the cycle it is present
      do_reset();
      drive(0, 0, 0, 1, 5, 0, 5);
      chk("lu.noop", No_Op_o, 1);
      chk("lu.pcwrite", PCWrite_o, 0);
      tick();
      drive(0, 0, 0, 0, 5, 0, 5);
      chk("lu.after_noop", No_Op_o, 0);
      chk("lu.after_pcwrite", PCWrite_o, 1);
      tick();

      // memory wait acked on the fourth cycle
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1, 0, 0, 0, 0, 0, 0);
         chk($sformatf("mw.freeze%0d", c), Freeze_o, 1);
         chk($sformatf("mw.req%0d", c), dmem_req_o, 1);
         chk($sformatf("mw.pcwrite%0d", c), PCWrite_o, 0);
         tick();
      end
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("mw.ack_freeze", Freeze_o, 0);
      chk("mw.ack_req", dmem_req_o, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("mw.idle_req", dmem_req_o, 0);
      chk("mw.stall_cnt", stall_cnt_o, STATS ? 3 : 0);
      tick();

      // same-cycle ack: no freeze, stays in RUN (request drops with the access)
      do_reset();
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("sc.freeze", Freeze_o, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("sc.req_run", dmem_req_o, 0);
      chk("sc.stall_cnt", stall_cnt_o, 0);
      tick();

      // timeout after four unacked MWAIT cycles
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      for (int c = 0; c < TMO; c++) begin
         drive(1, 0, 0, 0, 0, 0, 0);
         chk($sformatf("to.fault_pre%0d", c), Fault_o, 0);
         chk($sformatf("to.freeze%0d", c), Freeze_o, 1);
         tick();
      end
      drive(1, 1, 0, 0, 0, 0, 0);
      chk("to.fault", Fault_o, 1);
      chk("to.halt_freeze", Freeze_o, 1);
      chk("to.halt_req", dmem_req_o, 0);
      tick();
      chk("to.fault_sticky", Fault_o, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      do_reset();
      #1;
      chk("to.cleared_freeze", Freeze_o, 0);
      chk("to.cleared_fault", Fault_o, 0);

      // branch suppressed by freeze until the ack
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1, 0, 1, 0, 0, 0, 0);
         chk($sformatf("pr.flush%0d", c), Flush_o, 0);
         tick();
      end
      drive(1, 1, 1, 0, 0, 0, 0);
      chk("pr.ack_flush", Flush_o, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("pr.after_flush", Flush_o, 0);
      chk("pr.flush_cnt", flush_cnt_o, STATS ? 1 : 0);
      tick();

      // reset while waiting drops the request
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      do_reset();

      // randomized run against the model
      halt_cycles = 0;
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         halt_cycles = m_halt ? halt_cycles + 1 : 0;
         if (halt_cycles > 3 || $urandom_range(0, 199) == 0) begin
            do_reset();
            halt_cycles = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter TIMEOUT_W, default 8, width of the memory-wait counter.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 200, maximum wait cycles for dmem_ack_i before a fault.
REQ-004 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-005 SHALL provide the following ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- ID_Rs1_i  in  REG_ADDR_W  ID-stage source register 1.
- ID_Rs2_i  in  REG_ADDR_W  ID-stage source register 2.
- EX_Rd_i  in  REG_ADDR_W  EX-stage destination register.
- EX_MemRead_i  in  1  EX-stage instruction is a load.
- MEM_Access_i  in  1  MEM-stage instruction reads or writes data memory.
- Branch_Taken_i  in  1  ID-stage branch resolved taken.
- dmem_ack_i  in  1  data-memory completion.
- dmem_req_o  out  1  data-memory request.
- PCWrite_o  out  1  PC update enable.
- IF_ID_Write_o  out  1  IF/ID register update enable.
- No_Op_o  out  1  bubble request; drives Control No_Op_i.
- Flush_o  out  1  IF/ID flush.
- Freeze_o  out  1  hold all pipeline registers.
- Fault_o  out  1  sticky memory-timeout fault.
- stall_cnt_o  out  CNT_W  stall-cycle count.
- flush_cnt_o  out  CNT_W  flush count.

Function
REQ-006 SHALL implement the FSM states RUN, MWAIT and HALT.
REQ-007 SHALL detect load-use as EX_MemRead_i & EX_Rd_i!=0 & (EX_Rd_i==ID_Rs1_i | EX_Rd_i==ID_Rs2_i), combinationally, in the same cycle.
REQ-008 SHALL, on load-use in RUN without freeze, drive PCWrite_o=0, IF_ID_Write_o=0 and No_Op_o=1 for exactly that cycle.
REQ-009 SHALL drive dmem_req_o=MEM_Access_i in RUN and hold dmem_req_o=1 throughout MWAIT.
REQ-010 SHALL drive Freeze_o=1 when (RUN & MEM_Access_i & !dmem_ack_i) or (MWAIT & !dmem_ack_i) or HALT.
REQ-011 SHALL transition RUN->MWAIT on MEM_Access_i & !dmem_ack_i; an access acked in the same cycle causes no stall and no state change.
REQ-012 SHALL, in MWAIT, increment the wait counter each cycle without ack, and transition MWAIT->RUN on dmem_ack_i with Freeze_o=0 in that cycle.
REQ-013 SHALL transition MWAIT->HALT and set Fault_o when the wait counter reaches MEM_TIMEOUT without ack; HALT is exited only by reset.
REQ-014 SHALL clear the wait counter on every entry to MWAIT.
REQ-015 SHALL drive Flush_o=Branch_Taken_i when Freeze_o=0 and no load-use is present.
REQ-016 SHALL apply priority freeze > load-use > flush; a lower-priority event suppressed in one cycle is re-evaluated from the held inputs in the next cycle.
REQ-017 SHALL force PCWrite_o=0, IF_ID_Write_o=0 and No_Op_o=0 whenever Freeze_o=1.
REQ-018 SHALL drive PCWrite_o=1, IF_ID_Write_o=1 and all other outputs 0 when no event is present.

Reset
REQ-019 SHALL, with rst_i=0, enter RUN asynchronously and clear the wait counter, Fault_o, stall_cnt_o and flush_cnt_o.
REQ-020 SHALL, on reset assertion in MWAIT or HALT, abandon the outstanding request and drive dmem_req_o=0 during reset.

Configuration
REQ-021 SHALL, with STALL_STATS_EN defined, count stall_cnt_o once per cycle in which Freeze_o or No_Op_o is 1, and count flush_cnt_o once per cycle in which Flush_o=1, both saturating at all-ones.
REQ-022 SHALL, with STALL_STATS_EN undefined, tie stall_cnt_o and flush_cnt_o to 0 and instantiate no counter flops.

Structure
REQ-023 SHALL place the FSM state enum (RUN, MWAIT, HALT) and the opcode constants shared with Control in package ctrl_pkg.
REQ-024 SHALL implement load-use detection in the combinational sub-module hazard_detect.

Verification
REQ-025 SHALL verify load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_Rs2_i=5 for one cycle -> PCWrite_o=0, IF_ID_Write_o=0, No_Op_o=1 for exactly 1 cycle; with EX_Rd_i=0 -> no stall.
REQ-026 SHALL verify memory wait: MEM_Access_i=1 with ack after 3 cycles -> Freeze_o=1 for 3 cycles, 0 on the ack cycle, and stall_cnt_o=3 with STALL_STATS_EN.
REQ-027 SHALL verify same-cycle ack: MEM_Access_i=1, dmem_ack_i=1 -> Freeze_o=0 and state remains RUN.
REQ-028 SHALL verify timeout: MEM_TIMEOUT=4 with no ack -> Fault_o=1 after 4 MWAIT cycles, Freeze_o stays 1, and rst_i=0 clears both.
REQ-029 SHALL verify priority: Branch_Taken_i=1 during a freeze -> Flush_o=0 until the ack, then Flush_o=1 for one cycle and flush_cnt_o=1.
